// File: rtl/divisor_sequencial_param.sv
// Multi-cycle restoring integer divider, one quotient bit per clock.
// Signed/unsigned operands, start/busy/done handshake, fast exit for /0 and MIN/-1.
module divisor_sequencial_param #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quociente,
  output logic [WIDTH-1:0] resto,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ZERO_W   = '0;
  localparam logic [WIDTH-1:0] ONES_W   = '1;
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIM  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Working registers: work shifts dividend bits out the top and quotient bits in the bottom
  logic [WIDTH-1:0] work_q, work_nxt;
  logic [WIDTH-1:0] dsr_q, dsr_nxt;
  logic [WIDTH-1:0] partial_q, partial_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             q_neg_q, q_neg_nxt;
  logic             r_neg_q, r_neg_nxt;

  logic [WIDTH-1:0] quociente_nxt, resto_nxt;
  logic             busy_nxt, done_nxt, div_zero_nxt, overflow_nxt;

  logic             dvd_neg_c, dsr_neg_c;
  logic [WIDTH-1:0] dvd_mag_c, dsr_mag_c;
  logic             fast_zero_c, fast_ovf_c;
  logic             last_iter_c;
  logic [WIDTH-1:0] partial_sh_c;
  logic [WIDTH:0]   trial_c;
  logic             qbit_c;
  logic [WIDTH-1:0] partial_it_c, work_it_c;
  logic [WIDTH-1:0] q_fin_c, r_fin_c;

  // Operand conditioning at accept time
  always_comb begin : operand_prep
    dvd_neg_c   = signed_mode & dividendo[WIDTH-1];
    dsr_neg_c   = signed_mode & divisor[WIDTH-1];
    dvd_mag_c   = dvd_neg_c ? (~dividendo + ONE_W) : dividendo;
    dsr_mag_c   = dsr_neg_c ? (~divisor + ONE_W) : divisor;
    fast_zero_c = (divisor == ZERO_W);
    fast_ovf_c  = signed_mode && (dividendo == MIN_W) && (divisor == ONES_W);
  end

  // One restoring step; trial is one bit wider so its MSB is the borrow
  always_comb begin : restoring_step
    partial_sh_c = {partial_q[WIDTH-2:0], work_q[WIDTH-1]};
    trial_c      = {1'b0, partial_sh_c} - {1'b0, dsr_q};
    qbit_c       = ~trial_c[WIDTH];
    partial_it_c = qbit_c ? trial_c[WIDTH-1:0] : partial_sh_c;
    work_it_c    = {work_q[WIDTH-2:0], qbit_c};
    q_fin_c      = q_neg_q ? (~work_it_c + ONE_W) : work_it_c;
    r_fin_c      = r_neg_q ? (~partial_it_c + ONE_W) : partial_it_c;
    last_iter_c  = (cnt_q == CNT_ONE);
  end

  always_ff @(posedge clk) begin : state_reg
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin : next_state
    state_nxt = state;
    case (state)
      IDLE, FIM: begin
        if (start) state_nxt = (fast_zero_c || fast_ovf_c) ? FIM : CALC;
      end
      CALC: begin
        if (last_iter_c) state_nxt = FIM;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin : output_next
    work_nxt      = work_q;
    dsr_nxt       = dsr_q;
    partial_nxt   = partial_q;
    cnt_nxt       = cnt_q;
    q_neg_nxt     = q_neg_q;
    r_neg_nxt     = r_neg_q;
    quociente_nxt = quociente;
    resto_nxt     = resto;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    div_zero_nxt  = div_zero;
    overflow_nxt  = overflow;
    case (state)
      IDLE, FIM: begin
        if (start) begin
          work_nxt     = dvd_mag_c;
          dsr_nxt      = dsr_mag_c;
          partial_nxt  = ZERO_W;
          cnt_nxt      = CNT_INIT;
          q_neg_nxt    = dvd_neg_c ^ dsr_neg_c;
          r_neg_nxt    = dvd_neg_c;
          div_zero_nxt = 1'b0;
          overflow_nxt = 1'b0;
          busy_nxt     = 1'b1;
          if (fast_zero_c) begin
            quociente_nxt = ONES_W;
            resto_nxt     = dividendo;
            div_zero_nxt  = 1'b1;
            busy_nxt      = 1'b0;
            done_nxt      = 1'b1;
          end else if (fast_ovf_c) begin
            quociente_nxt = MIN_W;
            resto_nxt     = ZERO_W;
            overflow_nxt  = 1'b1;
            busy_nxt      = 1'b0;
            done_nxt      = 1'b1;
          end
        end
      end
      CALC: begin
        work_nxt    = work_it_c;
        partial_nxt = partial_it_c;
        cnt_nxt     = cnt_q - CNT_ONE;
        if (last_iter_c) begin
          quociente_nxt = q_fin_c;
          resto_nxt     = r_fin_c;
          busy_nxt      = 1'b0;
          done_nxt      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin : data_reg
    if (!rst) begin
      work_q    <= ZERO_W;
      dsr_q     <= ZERO_W;
      partial_q <= ZERO_W;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      quociente <= ZERO_W;
      resto     <= ZERO_W;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      work_q    <= work_nxt;
      dsr_q     <= dsr_nxt;
      partial_q <= partial_nxt;
      cnt_q     <= cnt_nxt;
      q_neg_q   <= q_neg_nxt;
      r_neg_q   <= r_neg_nxt;
      quociente <= quociente_nxt;
      resto     <= resto_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      div_zero  <= div_zero_nxt;
      overflow  <= overflow_nxt;
    end
  end

endmodule

// File: tb/tb_divisor_sequencial_param.sv
// Bench for divisor_sequencial_param: 8- and 16-bit instances against an arithmetic
// reference model, plus directed operations with hand-computed results.
module tb_divisor_sequencial_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sm;
  logic        st8, st16;
  logic [7:0]  a8, b8, q8, r8;
  logic        bz8, dn8, dz8, ov8;
  logic [15:0] a16, b16, q16, r16;
  logic        bz16, dn16, dz16, ov16;

  divisor_sequencial_param #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .signed_mode(sm),
    .dividendo(a8), .divisor(b8), .quociente(q8), .resto(r8),
    .busy(bz8), .done(dn8), .div_zero(dz8), .overflow(ov8)
  );

  divisor_sequencial_param #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(st16), .signed_mode(sm),
    .dividendo(a16), .divisor(b16), .quociente(q16), .resto(r16),
    .busy(bz16), .done(dn16), .div_zero(dz16), .overflow(ov16)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state, index 0 = 8-bit instance, 1 = 16-bit instance
  int     m_left [2];
  longint pq [2], pr [2];
  longint eq [2], er [2];
  bit     eb [2], ed [2], edz [2], eov [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Truncating division as plain arithmetic on sign-extended values
  function automatic void ref_div(input int w, input bit s, input longint a, input longint b,
                                  output longint q, output longint r,
                                  output bit dz, output bit ov, output bit fast);
    longint mask, half, sa, sb;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    dz = 1'b0; ov = 1'b0; fast = 1'b0;
    if (b == 0) begin
      q = mask; r = a; dz = 1'b1; fast = 1'b1;
    end else if (s) begin
      sa = (a >= half) ? a - (mask + 1) : a;
      sb = (b >= half) ? b - (mask + 1) : b;
      if (sa == -half && sb == -1) begin
        q = half; r = 0; ov = 1'b1; fast = 1'b1;
      end else begin
        q = (sa / sb) & mask;
        r = (sa % sb) & mask;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic model_step(input int i, input int w, input bit s, input bit go,
                            input longint a, input longint b);
    longint q, r;
    bit dz, ov, f;
    ed[i] = 1'b0;
    if (m_left[i] > 0) begin
      m_left[i]--;
      if (m_left[i] == 0) begin
        eq[i] = pq[i]; er[i] = pr[i]; eb[i] = 1'b0; ed[i] = 1'b1;
      end
    end else if (go) begin
      ref_div(w, s, a, b, q, r, dz, ov, f);
      edz[i] = dz; eov[i] = ov;
      if (f) begin
        eq[i] = q; er[i] = r; ed[i] = 1'b1; eb[i] = 1'b0;
      end else begin
        pq[i] = q; pr[i] = r; eb[i] = 1'b1; m_left[i] = w;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_left[i] = 0; eq[i] = 0; er[i] = 0;
        eb[i] = 1'b0; ed[i] = 1'b0; edz[i] = 1'b0; eov[i] = 1'b0;
      end
      chk_en = 1'b1;
    end else begin
      model_step(0, 8, sm, st8, longint'(a8), longint'(b8));
      model_step(1, 16, sm, st16, longint'(a16), longint'(b16));
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m8_quociente", 32'(q8), 32'(eq[0]));
      chk("m8_resto", 32'(r8), 32'(er[0]));
      chk("m8_busy", 32'(bz8), 32'(eb[0]));
      chk("m8_done", 32'(dn8), 32'(ed[0]));
      chk("m8_div_zero", 32'(dz8), 32'(edz[0]));
      chk("m8_overflow", 32'(ov8), 32'(eov[0]));
      chk("m16_quociente", 32'(q16), 32'(eq[1]));
      chk("m16_resto", 32'(r16), 32'(er[1]));
      chk("m16_busy", 32'(bz16), 32'(eb[1]));
      chk("m16_done", 32'(dn16), 32'(ed[1]));
      chk("m16_div_zero", 32'(dz16), 32'(edz[1]));
      chk("m16_overflow", 32'(ov16), 32'(eov[1]));
    end
  end

  // Issue one 8-bit op from a negedge; returns on the negedge where done is seen
  task automatic run8(input string name, input bit s, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] xq, input logic [7:0] xr, input bit xdz, input bit xov,
                      input int xlat, input int xbusy);
    int lat = 0;
    int nb = 0;
    bit seen = 1'b0;
    sm = s; a8 = a; b8 = b; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      if (k > 1) @(negedge clk);
      if (bz8) nb++;
      if (dn8) begin seen = 1'b1; lat = k; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_done expected=done", name);
    end
    chk({name, "_latency"}, 32'(lat), 32'(xlat));
    chk({name, "_busy_cycles"}, 32'(nb), 32'(xbusy));
    chk({name, "_quociente"}, 32'(q8), 32'(xq));
    chk({name, "_resto"}, 32'(r8), 32'(xr));
    chk({name, "_div_zero"}, 32'(dz8), 32'(xdz));
    chk({name, "_overflow"}, 32'(ov8), 32'(xov));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    rst = 1'b0; sm = 1'b0;
    st8 = 1'b0; a8 = '0; b8 = '0;
    st16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(negedge clk);
    chk("rst_quociente", 32'(q8), 32'h0);
    chk("rst_resto", 32'(r8), 32'h0);
    chk("rst_busy_done", 32'({bz8, dn8}), 32'h0);
    chk("rst_flags", 32'({dz8, ov8}), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    run8("u200_7",     1'b0, 8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 1'b0, 9, 8);
    run8("s_m100_7",   1'b1, 8'h9C,  8'd7,   8'hF2,  8'hFE,  1'b0, 1'b0, 9, 8);
    run8("s_min_m1",   1'b1, 8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, 1'b1, 1, 0);
    run8("u37_0",      1'b0, 8'd37,  8'd0,   8'hFF,  8'd37,  1'b1, 1'b0, 1, 0);
    run8("u9_3",       1'b0, 8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 1'b0, 9, 8);
    run8("s100_m7",    1'b1, 8'd100, 8'hF9,  8'hF2,  8'd2,   1'b0, 1'b0, 9, 8);
    run8("s_m100_m7",  1'b1, 8'h9C,  8'hF9,  8'd14,  8'hFE,  1'b0, 1'b0, 9, 8);
    run8("u255_254",   1'b0, 8'hFF,  8'hFE,  8'd1,   8'd1,   1'b0, 1'b0, 9, 8);
    run8("u128_255",   1'b0, 8'h80,  8'hFF,  8'd0,   8'h80,  1'b0, 1'b0, 9, 8);
    run8("s_min_1",    1'b1, 8'h80,  8'd1,   8'h80,  8'd0,   1'b0, 1'b0, 9, 8);
    run8("s_m5_0",     1'b1, 8'hFB,  8'd0,   8'hFF,  8'hFB,  1'b1, 1'b0, 1, 0);
    run8("u7_200",     1'b0, 8'd7,   8'd200, 8'd0,   8'd7,   1'b0, 1'b0, 9, 8);

    // 16-bit op with an ignored start pulse in the middle of CALC
    sm = 1'b0; a16 = 16'd65535; b16 = 16'd255; st16 = 1'b1;
    @(negedge clk);
    st16 = 1'b0;
    lat = 0; seen = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 3) begin a16 = 16'd100; b16 = 16'd3; st16 = 1'b1; end
      if (k == 4) st16 = 1'b0;
      if (dn16) begin seen = 1'b1; lat = k; end
    end
    chk("w16_latency", 32'(lat), 32'd17);
    chk("w16_quociente", 32'(q16), 32'd257);
    chk("w16_resto", 32'(r16), 32'd0);
    repeat (20) @(negedge clk);
    chk("w16_no_second_op", 32'(q16), 32'd257);

    // Reset in the middle of CALC aborts without a done pulse
    sm = 1'b0; a8 = 8'd50; b8 = 8'd5; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_quociente", 32'(q8), 32'h0);
    chk("abort_resto", 32'(r8), 32'h0);
    chk("abort_busy_done", 32'({bz8, dn8}), 32'h0);
    chk("abort_flags", 32'({dz8, ov8}), 32'h0);
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(dn8), 32'h0);
    end
    run8("u50_5", 1'b0, 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 1'b0, 9, 8);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
